// File: rtl/inst_fetch.sv
// inst_fetch: front-end fetch stage feeding the instruction queue.
//
// Keeps the fetch PC and looks it up in a direct-mapped, one-word-per-line
// instruction cache. A miss parks the stage in WAIT and issues a refill to
// the memory controller. Each hit is pushed to the instruction queue (when
// it has room), and the branch predictor supplies the next PC. The ROB and
// the decoder can redirect the PC; the ROB has priority.
//
// Ports:
//   clk_in, rst_n_in, rdy_in         clock, sync active-low reset, global stall
//   if_mc_en_out/addr_out            refill request (held until done)
//   mc_if_done_in/data_in            refill completion pulse and word
//   if_bp_pc_out/inst_out            current PC and looked-up word to predictor
//   bp_if_pc_in                      predicted next PC
//   instqueue_if_rdy_in              queue can accept a word
//   if_instqueue_en/inst/pc_out      push strobe, word, and its PC
//   rob_if_rst_in/pc_in              ROB redirect
//   decoder_if_rst_in/pc_in          decoder redirect
module inst_fetch #(
    parameter int          ICacheLines = 64,
    parameter int          IndexWidth  = 6,
    parameter logic [31:0] ResetPC     = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    output logic        if_mc_en_out,
    output logic [31:0] if_mc_addr_out,
    input  logic        mc_if_done_in,
    input  logic [31:0] mc_if_data_in,
    output logic [31:0] if_bp_pc_out,
    output logic [31:0] if_bp_inst_out,
    input  logic [31:0] bp_if_pc_in,
    input  logic        instqueue_if_rdy_in,
    output logic        if_instqueue_en_out,
    output logic [31:0] if_instqueue_inst_out,
    output logic [31:0] if_instqueue_pc_out,
    input  logic        rob_if_rst_in,
    input  logic [31:0] rob_if_pc_in,
    input  logic        decoder_if_rst_in,
    input  logic [31:0] decoder_if_pc_in
);

    localparam int TagWidth = 30 - IndexWidth;

    typedef enum logic {FETCH, WAIT} state_t;

    state_t state, state_next;

    logic [31:0]            pc;
    logic [ICacheLines-1:0] valid;
    logic [TagWidth-1:0]    tag_mem  [ICacheLines];
    logic [31:0]            data_mem [ICacheLines];

    logic [IndexWidth-1:0]  index, miss_index;
    logic [TagWidth-1:0]    tag, miss_tag;
    logic                   hit, fill, redirect;
    logic [31:0]            redirect_pc;

    assign index       = pc[IndexWidth+1:2];
    assign tag         = pc[31:IndexWidth+2];
    assign hit         = valid[index] && (tag_mem[index] == tag);
    // A fill only completes a request that is actually outstanding.
    assign fill        = (state == WAIT) && mc_if_done_in;
    assign redirect    = rob_if_rst_in || decoder_if_rst_in;
    assign redirect_pc = rob_if_rst_in ? rob_if_pc_in : decoder_if_pc_in;

    assign if_bp_pc_out   = pc;
    assign if_bp_inst_out = data_mem[index];

    // A redirect in FETCH suppresses the miss request for the old-path PC;
    // a redirect in WAIT never cancels the outstanding refill.
    always_comb begin
        state_next = state;
        case (state)
            FETCH: if (!redirect && !hit) state_next = WAIT;
            WAIT:  if (mc_if_done_in)     state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in)   state <= FETCH;
        else if (rdy_in) state <= state_next;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            pc                    <= ResetPC;
            valid                 <= '0;
            miss_index            <= '0;
            miss_tag              <= '0;
            if_mc_en_out          <= 1'b0;
            if_mc_addr_out        <= 32'h0;
            if_instqueue_en_out   <= 1'b0;
            if_instqueue_inst_out <= 32'h0;
            if_instqueue_pc_out   <= 32'h0;
        end else if (rdy_in) begin
            if (fill) begin
                valid[miss_index] <= 1'b1;
                if_mc_en_out      <= 1'b0;
            end
            if (redirect) begin
                pc                  <= redirect_pc;
                if_instqueue_en_out <= 1'b0;
            end else if (state == FETCH) begin
                if (hit) begin
                    if (instqueue_if_rdy_in) begin
                        if_instqueue_en_out   <= 1'b1;
                        if_instqueue_inst_out <= data_mem[index];
                        if_instqueue_pc_out   <= pc;
                        pc                    <= bp_if_pc_in;
                    end else begin
                        if_instqueue_en_out <= 1'b0;
                    end
                end else begin
                    if_instqueue_en_out <= 1'b0;
                    miss_index          <= index;
                    miss_tag            <= tag;
                    if_mc_en_out        <= 1'b1;
                    if_mc_addr_out      <= pc;
                end
            end else begin
                if_instqueue_en_out <= 1'b0;
            end
        end
    end

    // Line payload needs no reset; the valid bits gate every use of it.
    always_ff @(posedge clk_in) begin
        if (rst_n_in && rdy_in && fill) begin
            data_mem[miss_index] <= mc_if_data_in;
            tag_mem[miss_index]  <= miss_tag;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed bench for inst_fetch. A small memory-controller
// model answers each refill three cycles after the request with 0x13|addr;
// the predictor model is a mode-selected function of the current PC.
module tb_inst_fetch;

    logic        clk, rst_n, rdy;
    logic        mc_en, mc_done;
    logic [31:0] mc_addr, mc_data;
    logic [31:0] bp_pc_out, bp_inst, bp_next;
    logic        iq_rdy, iq_en;
    logic [31:0] iq_inst, iq_pc;
    logic        rob_rst, dec_rst;
    logic [31:0] rob_pc, dec_pc;

    int n_checks = 0;
    int n_fail   = 0;
    int bp_mode  = 1;
    int mc_cnt   = 0;

    inst_fetch dut (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
        .if_mc_en_out(mc_en), .if_mc_addr_out(mc_addr),
        .mc_if_done_in(mc_done), .mc_if_data_in(mc_data),
        .if_bp_pc_out(bp_pc_out), .if_bp_inst_out(bp_inst),
        .bp_if_pc_in(bp_next),
        .instqueue_if_rdy_in(iq_rdy),
        .if_instqueue_en_out(iq_en), .if_instqueue_inst_out(iq_inst),
        .if_instqueue_pc_out(iq_pc),
        .rob_if_rst_in(rob_rst), .rob_if_pc_in(rob_pc),
        .decoder_if_rst_in(dec_rst), .decoder_if_pc_in(dec_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode 1: 0 -> 4 -> 8 -> 0 loop (plain +4 elsewhere); mode 2: 0 <-> 0x100
    assign bp_next = (bp_mode == 2) ? ((bp_pc_out == 32'h0) ? 32'h100 : 32'h0)
                   : ((bp_pc_out == 32'h8) ? 32'h0 : bp_pc_out + 32'h4);

    always @(negedge clk) begin
        if (!rst_n) begin
            mc_cnt  = 0;
            mc_done = 1'b0;
        end else if (mc_done) begin
            mc_done = 1'b0;
        end else if (mc_en) begin
            mc_cnt = mc_cnt + 1;
            if (mc_cnt == 3) begin
                mc_done = 1'b1;
                mc_data = 32'h13 | mc_addr;
                mc_cnt  = 0;
            end
        end
    end

    typedef struct {
        logic        rdy, iq_rdy, rob_rst, dec_rst;
        logic [31:0] rob_pc, dec_pc;
        logic        exp_en;
        logic [31:0] exp_pc;
        logic        exp_mc_en;
        logic [31:0] exp_mc_addr;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input logic r, input logic q, input logic rr,
                                input logic [31:0] rp, input logic dr,
                                input logic [31:0] dp, input logic e,
                                input logic [31:0] p, input logic me,
                                input logic [31:0] ma);
        vec_t v;
        v.rdy = r; v.iq_rdy = q; v.rob_rst = rr; v.rob_pc = rp;
        v.dec_rst = dr; v.dec_pc = dp; v.exp_en = e; v.exp_pc = p;
        v.exp_mc_en = me; v.exp_mc_addr = ma;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; iq_rdy = 1'b1;
        rob_rst = 1'b0; rob_pc = 32'h0; dec_rst = 1'b0; dec_pc = 32'h0;
        mc_done = 1'b0; mc_data = 32'h0;

        // ---- reset state ----
        step(); step();
        chk("rst mc_en", {31'h0, mc_en}, 32'h0);
        chk("rst mc_addr", mc_addr, 32'h0);
        chk("rst iq_en", {31'h0, iq_en}, 32'h0);
        chk("rst iq_inst", iq_inst, 32'h0);
        chk("rst iq_pc", iq_pc, 32'h0);
        chk("rst pc", bp_pc_out, 32'h0);
        rst_n = 1'b1;

        // ---- cold start: refills of 0x0, 0x4, 0x8 and their pushes ----
        for (int c = 1; c <= 15; c++) begin
            step();
            chk($sformatf("cold c%0d iq_en", c), {31'h0, iq_en},
                {31'h0, (c == 5 || c == 10 || c == 15)});
            if (c == 1) chk("cold req0 addr", mc_addr, 32'h0);
            if (c >= 1 && c <= 3) chk($sformatf("cold c%0d mc_en", c), {31'h0, mc_en}, 32'h1);
            if (c == 4 || c == 5) chk($sformatf("cold c%0d mc_en", c), {31'h0, mc_en}, 32'h0);
            if (c == 5) begin
                chk("cold push0 pc", iq_pc, 32'h0);
                chk("cold push0 inst", iq_inst, 32'h13);
            end
            if (c == 6) begin
                chk("cold req4 en", {31'h0, mc_en}, 32'h1);
                chk("cold req4 addr", mc_addr, 32'h4);
            end
            if (c == 10) begin
                chk("cold push4 pc", iq_pc, 32'h4);
                chk("cold push4 inst", iq_inst, 32'h17);
            end
            if (c == 11) chk("cold req8 addr", mc_addr, 32'h8);
            if (c == 15) begin
                chk("cold push8 pc", iq_pc, 32'h8);
                chk("cold push8 inst", iq_inst, 32'h1b);
            end
        end

        // ---- warm loop, stall, backpressure, redirects (pc=0 here) ----
        //              rdy  q   rob   rob_pc   dec   dec_pc  en  exp_pc   mc  mc_addr
        vecs[0]  = mk(1, 1, 0, 0,       0, 0,      1, 32'h0,   0, 0);
        vecs[1]  = mk(1, 1, 0, 0,       0, 0,      1, 32'h4,   0, 0);
        vecs[2]  = mk(1, 1, 0, 0,       0, 0,      1, 32'h8,   0, 0);
        vecs[3]  = mk(1, 1, 0, 0,       0, 0,      1, 32'h0,   0, 0);
        vecs[4]  = mk(0, 1, 0, 0,       0, 0,      1, 32'h0,   0, 0);
        vecs[5]  = mk(0, 1, 0, 0,       0, 0,      1, 32'h0,   0, 0);
        vecs[6]  = mk(1, 0, 0, 0,       0, 0,      0, 0,       0, 0);
        vecs[7]  = mk(1, 0, 0, 0,       0, 0,      0, 0,       0, 0);
        vecs[8]  = mk(1, 0, 0, 0,       0, 0,      0, 0,       0, 0);
        vecs[9]  = mk(1, 0, 0, 0,       0, 0,      0, 0,       0, 0);
        vecs[10] = mk(1, 1, 0, 0,       0, 0,      1, 32'h4,   0, 0);
        vecs[11] = mk(1, 1, 0, 0,       0, 0,      1, 32'h8,   0, 0);
        vecs[12] = mk(1, 1, 0, 0,       0, 0,      1, 32'h0,   0, 0);
        vecs[13] = mk(1, 1, 0, 0,       1, 32'h8,  0, 0,       0, 0);
        vecs[14] = mk(1, 1, 0, 0,       0, 0,      1, 32'h8,   0, 0);
        vecs[15] = mk(1, 1, 1, 32'h200, 1, 32'h300, 0, 0,      0, 0);
        vecs[16] = mk(1, 1, 0, 0,       0, 0,      0, 0,       1, 32'h200);
        vecs[17] = mk(1, 1, 0, 0,       0, 0,      0, 0,       1, 32'h200);
        vecs[18] = mk(1, 1, 0, 0,       0, 0,      0, 0,       1, 32'h200);
        vecs[19] = mk(1, 1, 0, 0,       0, 0,      0, 0,       0, 0);
        vecs[20] = mk(1, 1, 0, 0,       0, 0,      1, 32'h200, 0, 0);

        for (int i = 0; i < 21; i++) begin
            rdy = vecs[i].rdy; iq_rdy = vecs[i].iq_rdy;
            rob_rst = vecs[i].rob_rst; rob_pc = vecs[i].rob_pc;
            dec_rst = vecs[i].dec_rst; dec_pc = vecs[i].dec_pc;
            step();
            chk($sformatf("vec%0d iq_en", i), {31'h0, iq_en}, {31'h0, vecs[i].exp_en});
            if (vecs[i].exp_en) begin
                chk($sformatf("vec%0d iq_pc", i), iq_pc, vecs[i].exp_pc);
                chk($sformatf("vec%0d iq_inst", i), iq_inst, 32'h13 | vecs[i].exp_pc);
            end
            chk($sformatf("vec%0d mc_en", i), {31'h0, mc_en}, {31'h0, vecs[i].exp_mc_en});
            if (vecs[i].exp_mc_en)
                chk($sformatf("vec%0d mc_addr", i), mc_addr, vecs[i].exp_mc_addr);
            if (i == 15) chk("rob wins pc", bp_pc_out, 32'h200);
        end
        rdy = 1'b1; iq_rdy = 1'b1;
        rob_rst = 1'b0; dec_rst = 1'b0;

        // ---- redirect during miss (pc=0x204 here) ----
        rob_rst = 1'b1; rob_pc = 32'h40;
        step();                                   // A: redirect in FETCH
        rob_rst = 1'b0;
        chk("rdA pc", bp_pc_out, 32'h40);
        chk("rdA mc_en", {31'h0, mc_en}, 32'h0);
        step();                                   // R: miss on 0x40
        chk("rdR mc_en", {31'h0, mc_en}, 32'h1);
        chk("rdR mc_addr", mc_addr, 32'h40);
        rob_rst = 1'b1; rob_pc = 32'h100;
        step();                                   // redirect while waiting
        rob_rst = 1'b0;
        chk("rdW pc", bp_pc_out, 32'h100);
        chk("rdW mc_en held", {31'h0, mc_en}, 32'h1);
        chk("rdW mc_addr held", mc_addr, 32'h40);
        step();
        chk("rdB iq_en", {31'h0, iq_en}, 32'h0);
        step();                                   // fill of 0x40 lands
        chk("rdC mc_en", {31'h0, mc_en}, 32'h0);
        chk("rdC iq_en", {31'h0, iq_en}, 32'h0);
        step();                                   // next request is redirect target
        chk("rdD mc_en", {31'h0, mc_en}, 32'h1);
        chk("rdD mc_addr", mc_addr, 32'h100);
        chk("rdD iq_en", {31'h0, iq_en}, 32'h0);
        step(); step(); step();                   // fill of 0x100
        chk("rdG mc_en", {31'h0, mc_en}, 32'h0);
        chk("rdG iq_en", {31'h0, iq_en}, 32'h0);
        step();
        chk("rdH iq_en", {31'h0, iq_en}, 32'h1);
        chk("rdH iq_pc", iq_pc, 32'h100);
        chk("rdH iq_inst", iq_inst, 32'h113);
        dec_rst = 1'b1; dec_pc = 32'h40;
        step();                                   // decoder redirect back to 0x40
        dec_rst = 1'b0;
        chk("rdI iq_en", {31'h0, iq_en}, 32'h0);
        bp_mode = 2;
        step();                                   // 0x40 hits: its fill landed
        chk("rdJ iq_en", {31'h0, iq_en}, 32'h1);
        chk("rdJ iq_pc", iq_pc, 32'h40);
        chk("rdJ iq_inst", iq_inst, 32'h53);
        chk("rdJ mc_en", {31'h0, mc_en}, 32'h0);

        // ---- alias 0x0 / 0x100 on line 0, then reset mid-WAIT ----
        step();
        chk("alK mc_en", {31'h0, mc_en}, 32'h1);
        chk("alK mc_addr", mc_addr, 32'h0);
        step(); step(); step();
        chk("alN mc_en", {31'h0, mc_en}, 32'h0);
        step();
        chk("alO iq_en", {31'h0, iq_en}, 32'h1);
        chk("alO iq_pc", iq_pc, 32'h0);
        step();
        chk("alP mc_en", {31'h0, mc_en}, 32'h1);
        chk("alP mc_addr", mc_addr, 32'h100);
        chk("alP iq_en", {31'h0, iq_en}, 32'h0);
        rst_n = 1'b0;
        step();
        chk("rsQ mc_en", {31'h0, mc_en}, 32'h0);
        chk("rsQ mc_addr", mc_addr, 32'h0);
        chk("rsQ iq_en", {31'h0, iq_en}, 32'h0);
        chk("rsQ iq_pc", iq_pc, 32'h0);
        chk("rsQ pc", bp_pc_out, 32'h0);
        rst_n = 1'b1;
        step();                                   // line 0 held 0x0 but is now invalid
        chk("rsR iq_en", {31'h0, iq_en}, 32'h0);
        chk("rsR mc_en", {31'h0, mc_en}, 32'h1);
        chk("rsR mc_addr", mc_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
